mem_arbiter_ctrl: RTL
=====================

Name: mem_arbiter_ctrl

Overview:
Parametrised successor to the single-port SRAM memory controller. It owns a byte-lane-writable word array and serves an instruction fetch port and a data load/store port through a round-robin arbiter. Loads use the byte offset for lane extraction; stores write only the addressed byte lanes; accesses can take a configurable number of wait states. Misaligned and out-of-range accesses are detected and reported. Sits between the core fetch/LSU stages and on-chip RAM.

Parameters:
XLEN, 64, data width; 32 or 64 only.
MEM_DEPTH, 262144, number of XLEN-bit words; power of two.
WAIT_STATES, 0, extra ACCESS cycles per legal access (0..15).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
imem_req  in  1  fetch request; held with imem_addr until imem_ready
imem_addr  in  XLEN  fetch byte address
imem_ready  out  1  one-cycle response pulse
imem_data  out  32  fetched instruction, valid with imem_ready
imem_err  out  1  fetch error, valid with imem_ready
dmem_req  in  1  data request; all dmem_* inputs held until dmem_ready
dmem_we  in  1  1=store, 0=load
dmem_addr  in  XLEN  data byte address
dmem_wdata  in  XLEN  store data, low-aligned (byte in [7:0])
dmem_size  in  3  0=byte 1=half 2=word 3=double
dmem_signed  in  1  sign-extend load result
dmem_ready  out  1  one-cycle response pulse
dmem_rdata  out  XLEN  load result, valid with dmem_ready; 0 for stores/errors
dmem_err  out  1  data error, valid with dmem_ready

Behaviour:
- Reset: state=IDLE, wait counter=0, last_grant=DATA, all outputs 0. Array contents are not reset. A reset mid-access aborts it; any store not yet committed is dropped.
- FSM: IDLE -> ACCESS (legal request) or RESP (error); ACCESS stays WAIT_STATES+1 cycles; ACCESS -> RESP; RESP -> IDLE. Ready/err/data outputs are driven only in RESP and are registered.
- Arbitration is evaluated in IDLE only. With a single request, that port is granted. With both requesting, the port not equal to last_grant is granted, then last_grant updates. The first simultaneous request after reset therefore goes to the instruction port.
- Latency, legal access: ready is asserted WAIT_STATES+2 cycles after the request is sampled in IDLE. Error latency is 1 cycle. The minimum back-to-back issue interval for one port is WAIT_STATES+3 cycles.
- Word index = addr[log2(XLEN/8)+log2(MEM_DEPTH)-1 : log2(XLEN/8)]. The offset is the low log2(XLEN/8) bits.
- Errors (no array access, rdata=0):
  - Address bits above the word index are non-zero.
  - Fetch address with addr[1:0]!=0.
  - Data address not aligned to 2^size.
  - size=3 when XLEN=32, or size>3.
- Fetch: imem_data = the 32-bit lane selected by addr[2] (XLEN=64); the whole word when XLEN=32.
- Load: the lane at the offset is shifted to bit 0, then zero- or sign-extended to XLEN. dmem_signed is ignored for a full-XLEN load.
- Store: byte-enable mask = (2^(2^size))-1 shifted left by the offset. wdata is shifted into the same lanes. The write commits on the last ACCESS cycle; other lanes are unchanged.
- Read-after-write to the same address in the next request returns the new data.

Optional Feature:
MEMCTL_STATS_EN:
- When defined, three extra outputs are added: stat_ifetch (32), stat_data (32), stat_err (32).
- stat_ifetch and stat_data increment on each imem_ready / dmem_ready without an error. stat_err increments on each error response.
- All three saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. XLEN=64, WAIT_STATES=0. Store double 0x1122334455667788 at 0x100, then load byte signed at 0x107 -> dmem_ready 2 cycles after request; rdata=0x0000000000000011. Then load half unsigned at 0x104 -> 0x3344.
2. Store byte 0xAB at 0x101 over the word above, then load double at 0x100 -> 0x112233445566AB88. Load byte signed at 0x101 -> 0xFFFFFFFFFFFFFFAB.
3. imem_req and dmem_req asserted together and held for two transactions -> imem granted first, then dmem. last_grant alternates; neither port starves over 10 transactions.
4. Load word at 0x102 -> dmem_err=1 one cycle after request, rdata=0, array unchanged. Fetch at 0x2 -> imem_err=1. Address 0x800000 with MEM_DEPTH=262144 -> dmem_err=1.
5. WAIT_STATES=3. Fetch at 0x4 holding word 0xDEADBEEF_00000013 at 0x0 -> imem_ready 5 cycles after request, imem_data=0xDEADBEEF.
6. Assert reset for one cycle during ACCESS of a store 0xFF to 0x10 -> no ready pulse; a load at 0x10 returns the prior value. With MEMCTL_STATS_EN, all counters read 0 after reset.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin fetch/data arbiter in front of a byte-lane-writable word array.
// Optional MEMCTL_STATS_EN adds saturating response counters.
module mem_arbiter_ctrl #(
    parameter int XLEN        = 64,
    parameter int MEM_DEPTH   = 262144,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_addr,
    output logic            imem_ready,
    output logic [31:0]     imem_data,
    output logic            imem_err,
    input  logic            dmem_req,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [2:0]      dmem_size,
    input  logic            dmem_signed,
    output logic            dmem_ready,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_err
`ifdef MEMCTL_STATS_EN
    ,
    output logic [31:0]     stat_ifetch,
    output logic [31:0]     stat_data,
    output logic [31:0]     stat_err
`endif
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int AW    = OFF_W + IDX_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_IMEM, PORT_DMEM} port_t;

    state_t          state, state_n;
    port_t           last_grant, cur_port;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic            signed_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] mem [MEM_DEPTH];

    logic            grant_any, grant_dmem, req_err, last_access;
    logic [XLEN-1:0] sel_addr;
    logic [OFF_W-1:0] align_mask;

    logic [IDX_W-1:0] idx_q;
    logic [OFF_W-1:0] off_q;
    logic [XLEN-1:0] word, shifted, lane_mask, sign_pos, load_val, wdata_sh;
    logic [NB-1:0]   be;

    // Request decode; only consulted while IDLE.
    always_comb begin
        grant_any  = imem_req | dmem_req;
        grant_dmem = dmem_req & (~imem_req | (last_grant == PORT_IMEM));
        sel_addr   = grant_dmem ? dmem_addr : imem_addr;
        align_mask = OFF_W'((32'd1 << dmem_size) - 32'd1);
        req_err    = (sel_addr >> AW) != '0;
        if (grant_dmem)
            req_err = req_err | (int'(dmem_size) > OFF_W)
                    | ((dmem_addr[OFF_W-1:0] & align_mask) != '0);
        else
            req_err = req_err | (imem_addr[1:0] != 2'b00);
    end

    assign last_access = (state == ACCESS) && (wait_cnt == 4'(WAIT_STATES));
    assign idx_q       = addr_q[AW-1:OFF_W];
    assign off_q       = addr_q[OFF_W-1:0];

    // Lane extraction: sign bit is the top set bit of the lane mask.
    always_comb begin
        word      = mem[idx_q];
        shifted   = word >> {off_q, 3'b000};
        lane_mask = '1;
        if (int'(size_q) < OFF_W)
            lane_mask = ~({XLEN{1'b1}} << (32'd8 << size_q));
        sign_pos  = lane_mask & ~(lane_mask >> 1);
        load_val  = shifted & lane_mask;
        if (signed_q && ((shifted & sign_pos) != '0))
            load_val = load_val | ~lane_mask;
        be        = NB'(((32'd1 << (32'd1 << size_q)) - 32'd1) << off_q);
        wdata_sh  = wdata_q << {off_q, 3'b000};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_any) state_n = req_err ? RESP : ACCESS;
            ACCESS:  if (last_access) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= PORT_DMEM;
            cur_port   <= PORT_DMEM;
            addr_q     <= '0;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= '0;
            wdata_q    <= '0;
            imem_ready <= 1'b0;
            imem_err   <= 1'b0;
            imem_data  <= '0;
            dmem_ready <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            state      <= state_n;
            imem_ready <= 1'b0;
            imem_err   <= 1'b0;
            imem_data  <= '0;
            dmem_ready <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_port   <= grant_dmem ? PORT_DMEM : PORT_IMEM;
                        last_grant <= grant_dmem ? PORT_DMEM : PORT_IMEM;
                        addr_q     <= sel_addr[AW-1:0];
                        we_q       <= grant_dmem & dmem_we;
                        wdata_q    <= dmem_wdata;
                        size_q     <= dmem_size;
                        signed_q   <= dmem_signed;
                        wait_cnt   <= '0;
                        if (req_err) begin
                            if (grant_dmem) begin
                                dmem_ready <= 1'b1;
                                dmem_err   <= 1'b1;
                            end else begin
                                imem_ready <= 1'b1;
                                imem_err   <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (last_access) begin
                        if (cur_port == PORT_DMEM) begin
                            dmem_ready <= 1'b1;
                            if (!we_q) dmem_rdata <= load_val;
                        end else begin
                            imem_ready <= 1'b1;
                            imem_data  <= shifted[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so a store interrupted on its commit edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && last_access && (cur_port == PORT_DMEM) && we_q) begin
            for (int unsigned i = 0; i < NB; i++)
                if (be[i]) mem[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end

`ifdef MEMCTL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ifetch <= '0;
            stat_data   <= '0;
            stat_err    <= '0;
        end else begin
            if (imem_ready && !imem_err && (stat_ifetch != '1))
                stat_ifetch <= stat_ifetch + 32'd1;
            if (dmem_ready && !dmem_err && (stat_data != '1))
                stat_data <= stat_data + 32'd1;
            if (((imem_ready && imem_err) || (dmem_ready && dmem_err)) && (stat_err != '1))
                stat_err <= stat_err + 32'd1;
        end
    end
`endif

endmodule
